// File: rtl/beep_scheduler_if.sv
// rtl/beep_scheduler_if.sv - request/tone bundle between menu logic, beep_scheduler and buzzer PWM
//
// Purpose: groups the beep_scheduler request inputs and tone/status outputs.
// Signals:
//   req         [2:0]  request pulses (bit2 alarm, bit1 OK confirm, bit0 key click)
//   sel         [1:0]  menu selection, picks the confirm pattern
//   busy               high from LOAD through the last note slot
//   grant       [2:0]  one-hot requester currently playing, 000 when idle
//   tone_en            high during the sounding part of a note
//   tone_period [16:0] tone period in clocks, 0 when tone_en=0
//   done               one-cycle pulse when a pattern completes
// Modports: master = requester/observer side, slave = beep_scheduler side.

interface beep_scheduler_if;
  logic [2:0]  req;
  logic [1:0]  sel;
  logic        busy;
  logic [2:0]  grant;
  logic        tone_en;
  logic [16:0] tone_period;
  logic        done;

  modport master (
    output req, sel,
    input  busy, grant, tone_en, tone_period, done
  );

  modport slave (
    input  req, sel,
    output busy, grant, tone_en, tone_period, done
  );
endinterface

// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - buzzer arbiter and note-pattern sequencer
//
// Purpose: arbitrates the buzzer between alarm, OK confirm and key click,
// then plays the granted source's note pattern as tone period/enable with a
// 25% mute gap at the end of every note slot.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   io_bus  beep_scheduler_if.slave (req/sel in; busy/grant/tone_en/tone_period/done out)
// Parameters:
//   CLK_PRE     clock frequency in Hz, note periods are CLK_PRE/freq
//   NOTE_TICKS  clock cycles per note slot
// Configuration macro:
//   BEEP_PREEMPT_EN  when defined, an alarm request aborts a playing click or
//                    confirm pattern (no done pulse, aborted request dropped).

module beep_scheduler #(
  parameter int CLK_PRE    = 50_000_000,
  parameter int NOTE_TICKS = 5_000_000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  beep_scheduler_if.slave io_bus
);

  localparam int CW = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NOTE_TICKS - 1);
  // First muted slot count: tone sounds for the first 75% of the slot.
  localparam logic [CW-1:0] CNT_MUTE = CW'((NOTE_TICKS >> 1) + (NOTE_TICKS >> 2));

  localparam logic [16:0] P_MI = 17'(CLK_PRE / 659);
  localparam logic [16:0] P_FA = 17'(CLK_PRE / 698);
  localparam logic [16:0] P_SO = 17'(CLK_PRE / 784);
  localparam logic [16:0] P_LA = 17'(CLK_PRE / 880);
  localparam logic [16:0] P_SI = 17'(CLK_PRE / 988);

  // MI is the lowest note, so it has the longest period.
  if ((CLK_PRE / 659) >= (1 << 17)) begin : g_width_chk
    $error("beep_scheduler: CLK_PRE/659 does not fit in 17 bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE} state_t;
  typedef enum logic [2:0] {PAT_CLICK, PAT_ALARM, PAT_CONF_LS, PAT_CONF_SL, PAT_CONF_SO} pat_t;

  function automatic logic [16:0] note_period(input pat_t p, input logic [1:0] idx);
    case (p)
      PAT_CLICK:   note_period = P_FA;
      PAT_ALARM:   note_period = idx[0] ? P_MI : P_SO;
      PAT_CONF_LS: note_period = idx[0] ? P_SI : P_LA;
      PAT_CONF_SL: note_period = idx[0] ? P_LA : P_SI;
      default:     note_period = P_SO;
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input pat_t p);
    case (p)
      PAT_ALARM:   last_idx = 2'd3;
      PAT_CONF_LS: last_idx = 2'd1;
      PAT_CONF_SL: last_idx = 2'd1;
      default:     last_idx = 2'd0;
    endcase
  endfunction

  state_t        r_state;
  pat_t          r_pat;
  logic [2:0]    r_pend;
  logic [2:0]    r_grant;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_tone_en;
  logic [16:0]   r_tone_period;
  logic          r_done;

  pat_t          w_pat_load;
  logic [2:0]    w_grant_pick;
  logic [2:0]    w_pend_clr;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_preempt;

  // sel only matters when the confirm source is being loaded.
  always_comb begin
    w_pat_load = PAT_CLICK;
    if (r_grant[2])
      w_pat_load = PAT_ALARM;
    else if (r_grant[1])
      w_pat_load = (io_bus.sel == 2'b00) ? PAT_CONF_LS :
                   (io_bus.sel == 2'b01) ? PAT_CONF_SL : PAT_CONF_SO;
  end

  assign w_grant_pick = r_pend[2] ? 3'b100 :
                        r_pend[1] ? 3'b010 :
                        r_pend[0] ? 3'b001 : 3'b000;

  // The granted source's pending bit drops in its LOAD cycle; a new pulse in
  // that same cycle re-arms it because the OR with req comes last.
  assign w_pend_clr = (r_state == S_LOAD) ? r_grant : 3'b000;
  assign w_cnt_nxt  = r_cnt + CW'(1);

`ifdef BEEP_PREEMPT_EN
  assign w_preempt = (r_state != S_IDLE) && !r_grant[2] && io_bus.req[2];
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_pat         <= PAT_CLICK;
      r_pend        <= 3'b000;
      r_grant       <= 3'b000;
      r_idx         <= 2'd0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_tone_en     <= 1'b0;
      r_tone_period <= 17'd0;
      r_done        <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_pend_clr) | io_bus.req;
      r_done <= 1'b0;
      if (w_preempt) begin
        // Abort silently and reload as alarm; the aborted source is not re-queued.
        r_state       <= S_LOAD;
        r_grant       <= 3'b100;
        r_busy        <= 1'b1;
        r_tone_en     <= 1'b0;
        r_tone_period <= 17'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (|r_pend) begin
              r_state <= S_LOAD;
              r_grant <= w_grant_pick;
              r_busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state       <= S_NOTE;
            r_pat         <= w_pat_load;
            r_idx         <= 2'd0;
            r_cnt         <= '0;
            r_tone_en     <= 1'b1;
            r_tone_period <= note_period(w_pat_load, 2'd0);
          end
          S_NOTE: begin
            if (r_cnt == CNT_LAST) begin
              if (r_idx != last_idx(r_pat)) begin
                r_idx         <= r_idx + 2'd1;
                r_cnt         <= '0;
                r_tone_en     <= 1'b1;
                r_tone_period <= note_period(r_pat, r_idx + 2'd1);
              end else begin
                r_state       <= S_IDLE;
                r_done        <= 1'b1;
                r_grant       <= 3'b000;
                r_busy        <= 1'b0;
                r_tone_en     <= 1'b0;
                r_tone_period <= 17'd0;
              end
            end else begin
              r_cnt <= w_cnt_nxt;
              if (w_cnt_nxt >= CNT_MUTE) begin
                r_tone_en     <= 1'b0;
                r_tone_period <= 17'd0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.grant       = r_grant;
  assign io_bus.tone_en     = r_tone_en;
  assign io_bus.tone_period = r_tone_period;
  assign io_bus.done        = r_done;

endmodule

// File: tb/tb_beep_scheduler.sv
// tb/tb_beep_scheduler.sv - directed self-checking bench for beep_scheduler
//
// Purpose: drives directed request/sel sequences with NOTE_TICKS=16 and checks
// grant, busy, tone and done against hand-computed values.
// Ports: none (top-level bench); instantiates beep_scheduler_if and beep_scheduler.

module tb_beep_scheduler;

  localparam int FA = 71633;
  localparam int SO = 63775;
  localparam int MI = 75872;
  localparam int LA = 56818;
  localparam int SI = 50607;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  beep_scheduler_if bus_if ();

  beep_scheduler #(
    .CLK_PRE    (50_000_000),
    .NOTE_TICKS (16)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, 32'(bus_if.busy), 0);
    chk({tag, " grant"}, 32'(bus_if.grant), 0);
    chk({tag, " tone_en"}, 32'(bus_if.tone_en), 0);
    chk({tag, " period"}, 32'(bus_if.tone_period), 0);
    chk({tag, " done"}, 32'(bus_if.done), 0);
  endtask

  task automatic pulse_req(input logic [2:0] v);
    bus_if.req = v;
    tick();
    bus_if.req = 3'b000;
  endtask

  // LOAD cycle: busy and grant up, tone still silent.
  task automatic load(input string tag, input logic [2:0] exp_grant);
    tick();
    bus_if.req = 3'b000;
    chk({tag, " load busy"}, 32'(bus_if.busy), 1);
    chk({tag, " load grant"}, 32'(bus_if.grant), 32'(exp_grant));
    chk({tag, " load tone_en"}, 32'(bus_if.tone_en), 0);
    chk({tag, " load done"}, 32'(bus_if.done), 0);
  endtask

  // n slot cycles of one note; 12 sounding then 4 muted for NOTE_TICKS=16.
  task automatic play_note(input string tag, input int period, input int n,
                           input logic [1:0] sel_after, input logic [2:0] req_val,
                           input logic [15:0] req_mask);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " busy"}, 32'(bus_if.busy), 1);
      chk({tag, " tone_en"}, 32'(bus_if.tone_en), (i < 12) ? 1 : 0);
      chk({tag, " period"}, 32'(bus_if.tone_period), (i < 12) ? period : 0);
      chk({tag, " done"}, 32'(bus_if.done), 0);
      if (i == 0) bus_if.sel = sel_after;
      bus_if.req = req_mask[i] ? req_val : 3'b000;
    end
  endtask

  task automatic end_pattern(input string tag);
    tick();
    bus_if.req = 3'b000;
    chk({tag, " end done"}, 32'(bus_if.done), 1);
    chk({tag, " end busy"}, 32'(bus_if.busy), 0);
    chk({tag, " end grant"}, 32'(bus_if.grant), 0);
    chk({tag, " end tone_en"}, 32'(bus_if.tone_en), 0);
  endtask

  task automatic play_alarm(input string tag);
    play_note({tag, " SO0"}, SO, 16, bus_if.sel, 3'b000, 16'h0000);
    play_note({tag, " MI1"}, MI, 16, bus_if.sel, 3'b000, 16'h0000);
    play_note({tag, " SO2"}, SO, 16, bus_if.sel, 3'b000, 16'h0000);
    play_note({tag, " MI3"}, MI, 16, bus_if.sel, 3'b000, 16'h0000);
  endtask

  initial begin
    int busy_seen;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus_if.req = 3'b000;
    bus_if.sel = 2'b00;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();
    chk_idle_outputs("post_reset");

    // 1: reset mid-alarm at cnt=5, with a click left pending
    pulse_req(3'b100);
    load("t1", 3'b100);
    play_note("t1 SO0", SO, 6, 2'b00, 3'b001, 16'h0004);
    rst = 1'b1;
    #1;
    chk_idle_outputs("t1 async_rst");
    tick();
    chk_idle_outputs("t1 rst_cycle");
    rst = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.busy || bus_if.done || (bus_if.grant != 3'b000)) busy_seen++;
    end
    chk("t1 idle_after_reset", 32'(busy_seen), 0);

    // 2: single click
    pulse_req(3'b001);
    load("t2", 3'b001);
    play_note("t2 FA", FA, 16, 2'b00, 3'b000, 16'h0000);
    end_pattern("t2");
    tick();
    chk("t2 done_one_cycle", 32'(bus_if.done), 0);

    // 3: confirm sel=00, sel changed to 01 during note 0
    bus_if.sel = 2'b00;
    pulse_req(3'b010);
    load("t3", 3'b010);
    play_note("t3 LA", LA, 16, 2'b01, 3'b000, 16'h0000);
    play_note("t3 SI", SI, 16, 2'b01, 3'b000, 16'h0000);
    end_pattern("t3");
    tick();
    chk_idle_outputs("t3 after");

    // 4: all three at once, priority order with one IDLE cycle between
    bus_if.sel = 2'b00;
    pulse_req(3'b111);
    load("t4 alarm", 3'b100);
    play_alarm("t4");
    end_pattern("t4 alarm");
    load("t4 confirm", 3'b010);
    play_note("t4 LA", LA, 16, 2'b00, 3'b000, 16'h0000);
    play_note("t4 SI", SI, 16, 2'b00, 3'b000, 16'h0000);
    end_pattern("t4 confirm");
    load("t4 click", 3'b001);
    play_note("t4 FA", FA, 16, 2'b00, 3'b000, 16'h0000);
    end_pattern("t4 click");
    tick();
    chk_idle_outputs("t4 after");

    // 5: two click pulses during click playback merge into one replay
    pulse_req(3'b001);
    load("t5", 3'b001);
    play_note("t5 FA", FA, 16, 2'b00, 3'b001, 16'h0088);
    end_pattern("t5");
    load("t5 replay", 3'b001);
    play_note("t5 FA replay", FA, 16, 2'b00, 3'b000, 16'h0000);
    end_pattern("t5 replay");
    tick();
    chk_idle_outputs("t5 after");

    // 6: alarm request at cnt=5 while click plays
    pulse_req(3'b001);
    load("t6", 3'b001);
`ifdef BEEP_PREEMPT_EN
    play_note("t6 FA", FA, 6, 2'b00, 3'b100, 16'h0020);
    load("t6 preempt", 3'b100);
`else
    play_note("t6 FA", FA, 16, 2'b00, 3'b100, 16'h0020);
    end_pattern("t6 click");
    load("t6 alarm", 3'b100);
`endif
    play_alarm("t6");
    end_pattern("t6 alarm");
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_if.busy || bus_if.done) busy_seen++;
    end
    chk("t6 no_replay", 32'(busy_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
